// File: rtl/md_ctrl_unit_if.sv
// E/D-stage bundle between the pipeline and the multiply/divide unit.
interface md_ctrl_unit_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      inst_e;
    logic [31:0]      inst_d;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             stall;
    logic             md_sel;
    logic [WIDTH-1:0] md_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output inst_e, inst_d, rs_val, rt_val,
        input  busy, stall, md_sel, md_out, hi, lo
    );

    modport slave (
        input  inst_e, inst_d, rs_val, rt_val,
        output busy, stall, md_sel, md_out, hi, lo
    );
endinterface

// File: rtl/md_ctrl_unit.sv
// MIPS multiply/divide sequencer and HI/LO file; results land MULT_CYCLES/DIV_CYCLES after start.
// No backpressure: a HI/LO consumer in D is held by a combinational stall while busy.
module md_ctrl_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    md_ctrl_unit_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             div_q, sgn_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             commit;

    logic       e_r, d_r;
    logic [5:0] e_f, d_f;
    logic       e_mult, e_div, e_mthi, e_mtlo, e_mfhi, e_mflo, d_md;
    logic       start;
    logic       unused_inst_bits;

    assign e_r = (bus.inst_e[31:26] == 6'd0);
    assign d_r = (bus.inst_d[31:26] == 6'd0);
    assign e_f = bus.inst_e[5:0];
    assign d_f = bus.inst_d[5:0];

    assign e_mult = e_r && (e_f == F_MULT || e_f == F_MULTU);
    assign e_div  = e_r && (e_f == F_DIV  || e_f == F_DIVU);
    assign e_mthi = e_r && (e_f == F_MTHI);
    assign e_mtlo = e_r && (e_f == F_MTLO);
    assign e_mfhi = e_r && (e_f == F_MFHI);
    assign e_mflo = e_r && (e_f == F_MFLO);
    // md-type functs occupy 0x10-0x13 and 0x18-0x1B
    assign d_md   = d_r && (d_f[5:2] == 4'b0100 || d_f[5:2] == 4'b0110);

    assign unused_inst_bits = ^{bus.inst_e[25:6], bus.inst_d[25:6]};

    assign start = (state_q == IDLE) && (e_mult || e_div);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = e_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            RUN: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Product: sign/zero-extend to 2W and keep the low 2W bits
    logic [W2-1:0] ext_a, ext_b, prod;
    assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

    // Quotient/remainder via magnitudes; MIN / -1 falls out as MIN, 0
    logic             a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_mag, b_mag, uq, ur, quo, rem;
    assign a_neg    = sgn_q && a_q[WIDTH-1];
    assign b_neg    = sgn_q && b_q[WIDTH-1];
    assign a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
    assign div_zero = (b_q == '0);

    always_comb begin
        uq = '0;
        ur = '0;
        if (!div_zero) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
    end

    assign quo = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    assign rem = a_neg ? (~ur + 1'b1) : ur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            sgn_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (start) begin
                a_q   <= bus.rs_val;
                b_q   <= bus.rt_val;
                div_q <= e_div;
                sgn_q <= (e_f == F_MULT) || (e_f == F_DIV);
            end
            if (commit) begin
                if (!div_q) begin
                    hi_q <= prod[W2-1:WIDTH];
                    lo_q <= prod[WIDTH-1:0];
                end else if (!div_zero) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end
            end else if (state_q == IDLE) begin
                if (e_mthi) hi_q <= bus.rs_val;
                if (e_mtlo) lo_q <= bus.rs_val;
            end
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.stall  = (start || bus.busy) && d_md;
    assign bus.md_sel = e_mfhi || e_mflo;
    assign bus.md_out = e_mfhi ? hi_q : (e_mflo ? lo_q : '0);
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule
